// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: fetch FSM state encodings and memory request size shared by the fetch stage
package inst_fetch_pkg;
  typedef enum logic {IF_IDLE = 1'b0, IF_WAIT = 1'b1} if_state_t;
  localparam logic [3:0] FETCH_BYTES = 4'd4;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: memctrl request/response (Insq_Mem, memctrl_*) and decoder queue (iq_*) signals; master = fetch stage
interface inst_fetch_if;
  logic        Insq_Mem;
  logic [31:0] memctrl_ins_addr;
  logic [3:0]  memctrl_remain;
  logic        memctrl_ins_ready;
  logic [31:0] memctrl_ins_;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pop;
  modport master (
    output Insq_Mem, memctrl_ins_addr, memctrl_remain, iq_valid, iq_inst, iq_pc,
    input  memctrl_ins_ready, memctrl_ins_, iq_pop
  );
  modport slave (
    input  Insq_Mem, memctrl_ins_addr, memctrl_remain, iq_valid, iq_inst, iq_pc,
    output memctrl_ins_ready, memctrl_ins_, iq_pop
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// fetch_queue: FIFO of 2^DEPTH_W entries; en freezes state, flush empties, push/pop/din in, valid/full/dout (head) out
module fetch_queue #(
  parameter int W = 64,
  parameter int DEPTH_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic         full,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [2**DEPTH_W];
  logic [DEPTH_W-1:0] head, tail;
  logic [DEPTH_W:0] count;
  logic do_push, do_pop;
  assign full = count[DEPTH_W];
  assign valid = |count;
  assign dout = mem[head];
  assign do_push = push && !full;
  assign do_pop = pop && valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      mem <= '{default: '0};
    end else if (en) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (do_push) mem[tail] <= din;
        tail <= tail + DEPTH_W'(do_push);
        head <= head + DEPTH_W'(do_pop);
        count <= count + (DEPTH_W+1)'(do_push) - (DEPTH_W+1)'(do_pop);
      end
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC + direct-mapped I-cache, one-outstanding miss FSM, fetch queue; ports clk, rst, rdy, clear, clear_pc, bus
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int QDEPTH_W = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  input logic        clear,
  input logic [31:0] clear_pc,
  inst_fetch_if.master bus
);
  localparam int LINES = 2 ** IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  if_state_t state, state_n;
  logic [31:0] pc, pc_n;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic hit, full, push, req, fill;
  logic [63:0] q_dout;
  assign idx = pc[IDX_W+1:2];
  assign tag = pc[31:IDX_W+2];
  assign hit = valid[idx] && tags[idx] == tag;
  assign req = !clear && state == IF_IDLE && !full && !hit;
  assign push = rdy && !clear && state == IF_IDLE && !full && hit;
  assign fill = !rst && rdy && !clear && state == IF_WAIT && bus.memctrl_ins_ready;
  assign {bus.iq_pc, bus.iq_inst} = q_dout;
  always_comb begin
    state_n = clear ? IF_IDLE : req ? IF_WAIT : fill ? IF_IDLE : state;
    pc_n = clear ? clear_pc : push ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_IDLE;
      pc <= RESET_PC;
      valid <= '0;
      bus.Insq_Mem <= 1'b0;
      bus.memctrl_ins_addr <= '0;
      bus.memctrl_remain <= '0;
    end else if (rdy) begin
      state <= state_n;
      pc <= pc_n;
      bus.Insq_Mem <= req;
      bus.memctrl_remain <= req ? FETCH_BYTES : 4'd0;
      if (req) bus.memctrl_ins_addr <= pc;
      if (fill) valid[idx] <= 1'b1;
    end else begin
      bus.Insq_Mem <= 1'b0;
      bus.memctrl_remain <= 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[idx] <= tag;
      data[idx] <= bus.memctrl_ins_;
    end
  end
  fetch_queue #(.W(64), .DEPTH_W(QDEPTH_W)) q (
    .clk(clk),
    .rst(rst),
    .en(rdy),
    .flush(clear),
    .push(push),
    .pop(bus.iq_pop),
    .din({pc, data[idx]}),
    .valid(bus.iq_valid),
    .full(full),
    .dout(q_dout)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a queue/cache reference model and a latency-6 memory responder
module tb_inst_fetch;
  import inst_fetch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  logic [31:0] clear_pc = '0;
  inst_fetch_if bus();
  inst_fetch dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .clear(clear),
    .clear_pc(clear_pc),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int n_req = 0;
  int r0;
  logic [63:0] mq[$];
  logic [31:0] m_pc = '0;
  bit m_wait = 0;
  bit exp_req = 0;
  logic [31:0] exp_addr = '0;
  bit c_v[64];
  logic [31:0] c_a[64];
  logic [31:0] c_d[64];
  int cnt = 0;
  logic [31:0] maddr = '0;
  function automatic bit cached(logic [31:0] a);
    return c_v[a[7:2]] && c_a[a[7:2]] == a;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    bit i_rst, i_rdy, i_clr, i_pop, i_mr, room, hit;
    logic [31:0] i_cpc, i_md;
    i_rst = rst; i_rdy = rdy; i_clr = clear; i_pop = bus.iq_pop; i_mr = bus.memctrl_ins_ready;
    i_cpc = clear_pc; i_md = bus.memctrl_ins_;
    @(posedge clk);
    if (i_rst) begin
      mq.delete(); m_pc = 32'h0; m_wait = 0; exp_req = 0;
      foreach (c_v[i]) c_v[i] = 0;
    end else if (!i_rdy) begin
      exp_req = 0;
    end else if (i_clr) begin
      mq.delete(); m_pc = i_cpc; m_wait = 0; exp_req = 0;
    end else begin
      room = mq.size() < 16;
      hit = cached(m_pc);
      exp_req = 0;
      if (i_pop && mq.size() > 0) void'(mq.pop_front());
      if (m_wait) begin
        if (i_mr) begin
          c_v[m_pc[7:2]] = 1; c_a[m_pc[7:2]] = m_pc; c_d[m_pc[7:2]] = i_md; m_wait = 0;
        end
      end else if (room && hit) begin
        mq.push_back({m_pc, c_d[m_pc[7:2]]}); m_pc = m_pc + 32'd4;
      end else if (room) begin
        exp_req = 1; exp_addr = m_pc; m_wait = 1;
      end
    end
    #1;
    chk("iq_valid", bus.iq_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("iq_pc", bus.iq_pc, mq[0][63:32]);
      chk("iq_inst", bus.iq_inst, mq[0][31:0]);
    end
    chk("insq_mem", bus.Insq_Mem, exp_req);
    if (exp_req) begin
      chk("req_addr", bus.memctrl_ins_addr, exp_addr);
      chk("req_remain", bus.memctrl_remain, 4);
    end else chk("idle_remain", bus.memctrl_remain, 0);
    if (bus.Insq_Mem) n_req++;
    if (i_rst) begin
      cnt = 0; bus.memctrl_ins_ready = 0;
    end else if (i_rdy) begin
      bus.memctrl_ins_ready = 0;
      if (i_clr) cnt = 0;
      if (bus.Insq_Mem) begin
        cnt = 6; maddr = bus.memctrl_ins_addr;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.memctrl_ins_ready = 1; bus.memctrl_ins_ = maddr ^ 32'hA5A5_0000;
        end
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.iq_pop = 0; bus.memctrl_ins_ready = 0; bus.memctrl_ins_ = '0;
    rst = 1; tick(); tick();
    chk("rst_valid", bus.iq_valid, 0);
    chk("rst_req", bus.Insq_Mem, 0);
    chk("rst_addr", bus.memctrl_ins_addr, 0);
    chk("rst_remain", bus.memctrl_remain, 0);
    chk("rst_inst", bus.iq_inst, 0);
    chk("rst_pc", bus.iq_pc, 0);
    rst = 0; tick();
    chk("first_req", {bus.Insq_Mem, bus.memctrl_ins_addr, bus.memctrl_remain}, {1'b1, 32'h0, 4'd4});
    for (int i = 0; i < 20 && !bus.iq_valid; i++) tick();
    chk("first_push_valid", bus.iq_valid, 1);
    chk("first_push_pc", bus.iq_pc, 32'h0);
    chk("first_push_inst", bus.iq_inst, 32'hA5A5_0000);
    tick();
    chk("second_req", {bus.Insq_Mem, bus.memctrl_ins_addr}, {1'b1, 32'h4});
    bus.iq_pop = 1;
    for (int i = 0; i < 2000 && m_pc != 32'h80; i++) tick();
    chk("cold_done", m_pc, 32'h80);
    bus.iq_pop = 0; clear = 1; clear_pc = 32'h0; tick(); clear = 0;
    r0 = n_req;
    repeat (16) tick();
    chk("warm_no_req", n_req - r0, 0);
    chk("warm_count", dut.q.count, 16);
    chk("warm_head", bus.iq_pc, 32'h0);
    repeat (3) tick();
    chk("full_pc", dut.pc, 32'h40);
    chk("full_count", dut.q.count, 16);
    chk("full_no_req", n_req - r0, 0);
    bus.iq_pop = 1; tick(); bus.iq_pop = 0;
    chk("pop_count", dut.q.count, 15);
    tick();
    chk("refill_count", dut.q.count, 16);
    chk("refill_pc", dut.pc, 32'h44);
    chk("refill_head", bus.iq_pc, 32'h4);
    clear = 1; clear_pc = 32'h0; tick(); clear = 0;
    bus.iq_pop = 1;
    repeat (3) tick();
    rdy = 0;
    repeat (5) tick();
    chk("frz_pc", dut.pc, 32'hC);
    chk("frz_count", dut.q.count, 1);
    rdy = 1; tick();
    clear = 1; clear_pc = 32'h200; tick(); clear = 0;
    r0 = n_req;
    tick();
    chk("wait_req", {bus.Insq_Mem, bus.memctrl_ins_addr}, {1'b1, 32'h200});
    rdy = 0;
    repeat (5) tick();
    chk("frz_state", dut.state, IF_WAIT);
    chk("frz_wait_pc", dut.pc, 32'h200);
    rdy = 1;
    for (int i = 0; i < 20 && !bus.iq_valid; i++) tick();
    chk("wait_single_req", n_req - r0, 1);
    chk("wait_push_pc", bus.iq_pc, 32'h200);
    clear = 1; clear_pc = 32'h300; tick(); clear = 0;
    tick();
    for (int i = 0; i < 20 && !bus.memctrl_ins_ready; i++) tick();
    chk("stale_resp_seen", bus.memctrl_ins_ready, 1);
    clear = 1; clear_pc = 32'h100; tick(); clear = 0;
    chk("stale_q_empty", bus.iq_valid, 0);
    tick();
    chk("stale_next_req", {bus.Insq_Mem, bus.memctrl_ins_addr}, {1'b1, 32'h100});
    for (int i = 0; i < 20 && !bus.iq_valid; i++) tick();
    chk("conf_pc", bus.iq_pc, 32'h100);
    chk("conf_inst", bus.iq_inst, 32'hA5A5_0100);
    clear = 1; clear_pc = 32'h0; tick(); clear = 0;
    tick();
    chk("conf_remiss", {bus.Insq_Mem, bus.memctrl_ins_addr}, {1'b1, 32'h0});
    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the memory controller's instruction port.
- Holds the PC and a direct-mapped instruction cache.
- On a miss it issues a 4-byte read to the memory controller and fills the cache from the returned word.
- Delivers {pc, inst} pairs in order through a FIFO to the decoder, and flushes on clear with redirect to a new PC.

Parameters:
- IDX_W, 6, cache index bits (2^IDX_W one-word lines)
- QDEPTH_W, 4, log2 of fetch-queue depth (16 entries)
- RESET_PC, 32'h0, PC after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low = all state frozen
- clear  in  1  pipeline flush / redirect
- clear_pc  in  32  redirect target, valid with clear
- Insq_Mem  out  1  one-cycle request pulse to the memory controller
- memctrl_ins_addr  out  32  request byte address (word aligned)
- memctrl_remain  out  4  bytes to read; always 4 when Insq_Mem=1, else 0
- memctrl_ins_ready  in  1  one-cycle response valid
- memctrl_ins_  in  32  little-endian instruction word
- iq_valid  out  1  queue non-empty
- iq_inst  out  32  head instruction
- iq_pc  out  32  head PC
- iq_pop  in  1  decoder consumes the head; ignored when iq_valid=0

Behaviour:
- Reset, sampled on posedge while rst=1:
  - pc=RESET_PC, state=IDLE.
  - All cache valid bits=0.
  - Queue head=tail=count=0.
  - Insq_Mem=0, memctrl_ins_addr=0, memctrl_remain=0.
  - iq_valid=0, iq_inst=0, iq_pc=0.
  - Reset mid-miss abandons the request; a later memctrl_ins_ready is ignored because state=IDLE.
- rdy=0 (rst=0): no register changes. Insq_Mem is forced 0, so requests never duplicate.
- Priority per edge: rst > !rdy > clear > normal.
- Cache address fields:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2] (30-IDX_W bits)
  - hit = valid[index] && tag_arr[index]==tag
- States:
  - IDLE:
    - Hit and count<2^QDEPTH_W: push {pc, data[index]}, pc<=pc+4 (32-bit wrap). One instruction per cycle.
    - Miss and count<2^QDEPTH_W: register Insq_Mem=1, memctrl_ins_addr=pc, memctrl_remain=4 for exactly one cycle; go to WAIT.
    - Queue full: hold.
  - WAIT:
    - Insq_Mem=0.
    - On memctrl_ins_ready: write data/tag/valid at pc's index, go to IDLE. The next IDLE cycle hits, so there is no direct bypass into the queue.
- Miss-to-push latency: 1 (request) + memory latency + 1 (IDLE hit) cycles.
- clear (rdy=1):
  - Queue emptied (count=0, head=tail), iq_valid=0 next cycle.
  - pc<=clear_pc, state<=IDLE.
  - Pending response dropped; the memory controller also cancels.
  - A memctrl_ins_ready in the same cycle as clear does NOT fill the cache.
  - Cache contents are retained across clear.
- Queue:
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty: ignored.
  - Full = count==2^QDEPTH_W. Push is blocked when full even if iq_pop is high that cycle (no same-cycle bypass).
  - Pointers wrap modulo 2^QDEPTH_W; count is QDEPTH_W+1 bits.
- Outputs iq_inst/iq_pc are combinational from the head entry. They hold the last head value when empty (don't-care).
- The block never issues a second request before the first completes or is cleared.

Decomposition:
- Shared package / defines file:
  - IF state encodings (IF_IDLE, IF_WAIT)
  - FETCH_BYTES=4 constant
  - Existing opcode defines unchanged
- One sub-module: fetch_queue (parameterised FIFO, push/pop/flush, count, head data). Cache arrays and FSM stay in inst_fetch.

Test Plan:
- Cold start, RESET_PC=0, memory model returns word=addr^32'hA5A5_0000 after 6 cycles: first Insq_Mem at cycle 1 after reset with addr=0, remain=4. iq_valid rises with iq_pc=0, iq_inst=32'hA5A5_0000. PC 4 is then requested.
- Warm loop: after fetching 0..0x3C, clear with clear_pc=0: no Insq_Mem for the next 16 pushes. One push per cycle, iq_pc=0,4,...,0x3C.
- Queue full: no pops, all hits: count stops at 16, pc frozen at 0x40, no request. One iq_pop then gives exactly one more push next cycle.
- Clear during WAIT with clear_pc=0x100; stale memctrl_ins_ready for the old address arrives in the same cycle: no cache fill, next request addr=0x100, queue empty.
- Conflict miss: fetch 0x0, then redirect to 0x100 (same index for IDX_W=6): miss, refill. Re-fetch of 0x0 misses again.
- rdy low for 5 cycles in the middle of a hit stream and in the WAIT state: pc, count and state unchanged. Insq_Mem never asserted twice for one miss.
